// File: rtl/byte_striping_ctrl_if.sv
// rtl/byte_striping_ctrl_if.sv - upstream byte handshake and striper lane bus
interface byte_striping_ctrl_if #(
    parameter int PAD_CNT_W = 16
);
    logic [7:0]           byteIN;
    logic                 byteVLD;
    logic                 byteRDY;
    logic [1:0]           laneModeIN;
    logic [7:0]           laneByteOUT;
    logic [1:0]           laneSelOUT;
    logic [3:0]           laneWE;
    logic                 groupDoneOUT;
    logic [1:0]           activeModeOUT;
    logic [PAD_CNT_W-1:0] padCountOUT;

    modport master (
        output byteIN, byteVLD, laneModeIN,
        input  byteRDY, laneByteOUT, laneSelOUT, laneWE,
        input  groupDoneOUT, activeModeOUT, padCountOUT
    );

    modport slave (
        input  byteIN, byteVLD, laneModeIN,
        output byteRDY, laneByteOUT, laneSelOUT, laneWE,
        output groupDoneOUT, activeModeOUT, padCountOUT
    );
endinterface

// File: rtl/byte_striping_ctrl.sv
// rtl/byte_striping_ctrl.sv - round-robin byte striping sequencer with PAD group closing
module byte_striping_ctrl #(
    parameter logic [7:0] PAD_BYTE  = 8'hF7,
    parameter int         PAD_CNT_W = 16
) (
    input  logic                 stripingCtrlCLK,
    input  logic                 stripingCtrlRST,
    byte_striping_ctrl_if.slave  strp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STRIPE = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [1:0]           lane_idx, lane_idx_d;
    logic [7:0]           lane_byte, lane_byte_d;
    logic [1:0]           lane_sel, lane_sel_d;
    logic [3:0]           lane_we, lane_we_d;
    logic                 group_done, group_done_d;
    logic [1:0]           active_mode, active_mode_d;
    logic [PAD_CNT_W-1:0] pad_count, pad_count_d;
    logic                 xfer;
    logic [1:0]           req_mode;

    // Reserved width code 11 behaves as x4.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == 2'b11) ? 2'b10 : m;
    endfunction

    // Index of the last active lane for a latched mode.
    function automatic logic [1:0] last_lane(input logic [1:0] m);
        case (m)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign strp.byteRDY       = !stripingCtrlRST && (state != ST_PAD);
    assign xfer               = strp.byteVLD && strp.byteRDY;
    assign req_mode           = map_mode(strp.laneModeIN);

    assign strp.laneByteOUT   = lane_byte;
    assign strp.laneSelOUT    = lane_sel;
    assign strp.laneWE        = lane_we;
    assign strp.groupDoneOUT  = group_done;
    assign strp.activeModeOUT = active_mode;
    assign strp.padCountOUT   = pad_count;

    // Next-state and next-output decode; lane writes are registered one cycle after the decision.
    always_comb begin
        state_d       = state;
        lane_idx_d    = lane_idx;
        lane_byte_d   = lane_byte;
        lane_sel_d    = lane_sel;
        lane_we_d     = 4'b0000;
        group_done_d  = 1'b0;
        active_mode_d = active_mode;
        pad_count_d   = pad_count;

        case (state)
            ST_IDLE: begin
                // The mode is resampled every idle cycle, and the byte accepted on
                // this edge already uses the newly requested mode.
                active_mode_d = req_mode;
                if (xfer) begin
                    lane_byte_d = strp.byteIN;
                    lane_sel_d  = 2'd0;
                    lane_we_d   = 4'b0001;
                    if (last_lane(req_mode) == 2'd0) begin
                        group_done_d = 1'b1;
                        lane_idx_d   = 2'd0;
                    end else begin
                        lane_idx_d = 2'd1;
                        state_d    = ST_STRIPE;
                    end
                end
            end

            ST_STRIPE: begin
                if (xfer) begin
                    lane_byte_d = strp.byteIN;
                    lane_sel_d  = lane_idx;
                    lane_we_d   = 4'b0001 << lane_idx;
                    if (lane_idx == last_lane(active_mode)) begin
                        group_done_d = 1'b1;
                        lane_idx_d   = 2'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        lane_idx_d = lane_idx + 2'd1;
                    end
                end else if (!strp.byteVLD) begin
                    // Upstream gap inside an open group: close it with PAD bytes.
                    state_d = ST_PAD;
                end
            end

            ST_PAD: begin
                lane_byte_d = PAD_BYTE;
                lane_sel_d  = lane_idx;
                lane_we_d   = 4'b0001 << lane_idx;
                pad_count_d = (&pad_count) ? pad_count : pad_count + 1'b1;
                if (lane_idx == last_lane(active_mode)) begin
                    group_done_d = 1'b1;
                    lane_idx_d   = 2'd0;
                    state_d      = ST_IDLE;
                end else begin
                    lane_idx_d = lane_idx + 2'd1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                lane_idx_d = 2'd0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any open group without padding.
    always_ff @(posedge stripingCtrlCLK) begin
        if (stripingCtrlRST) begin
            state       <= ST_IDLE;
            lane_idx    <= 2'd0;
            lane_byte   <= 8'h00;
            lane_sel    <= 2'd0;
            lane_we     <= 4'b0000;
            group_done  <= 1'b0;
            active_mode <= 2'b10;
            pad_count   <= '0;
        end else begin
            state       <= state_d;
            lane_idx    <= lane_idx_d;
            lane_byte   <= lane_byte_d;
            lane_sel    <= lane_sel_d;
            lane_we     <= lane_we_d;
            group_done  <= group_done_d;
            active_mode <= active_mode_d;
            pad_count   <= pad_count_d;
        end
    end

endmodule

// File: tb/tb_byte_striping_ctrl.sv
// tb/tb_byte_striping_ctrl.sv - self-checking bench for byte_striping_ctrl
module tb_byte_striping_ctrl;

    localparam int         PCW     = 3;
    localparam logic [7:0] PAD_VAL = 8'hF7;

    logic clk;
    logic rst;

    byte_striping_ctrl_if #(.PAD_CNT_W(PCW)) bus ();

    byte_striping_ctrl #(.PAD_BYTE(PAD_VAL), .PAD_CNT_W(PCW)) dut (
        .stripingCtrlCLK (clk),
        .stripingCtrlRST (rst),
        .strp            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_width  = 4;
    int         m_filled = 0;
    bit         m_padding = 0;
    int         m_pads   = 0;
    logic [1:0] m_mode   = 2'b10;
    logic [3:0] m_we     = 4'b0;
    logic [7:0] m_byte   = 8'h00;
    logic [1:0] m_sel    = 2'd0;
    bit         m_done   = 0;

    function automatic int lanes_of(input logic [1:0] code);
        if (code == 2'b00) return 1;
        if (code == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] code_of(input int lanes);
        if (lanes == 1) return 2'b00;
        if (lanes == 2) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_write(input int lane, input logic [7:0] data);
        m_we     = 4'(1 << lane);
        m_sel    = 2'(lane);
        m_byte   = data;
        m_filled = m_filled + 1;
        if (m_filled == m_width) begin
            m_done    = 1;
            m_filled  = 0;
            m_padding = 0;
        end
    endtask

    // Model advances on each clock edge from the inputs present before that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_filled = 0; m_padding = 0; m_pads = 0; m_mode = 2'b10;
            m_we = 0; m_byte = 0; m_sel = 0; m_done = 0;
        end else begin
            m_we   = 0;
            m_done = 0;
            if (m_padding) begin
                if (m_pads < (1 << PCW) - 1) m_pads = m_pads + 1;
                model_write(m_filled, PAD_VAL);
            end else if (m_filled == 0) begin
                m_width = lanes_of(bus.laneModeIN);
                m_mode  = code_of(m_width);
                if (bus.byteVLD) model_write(0, bus.byteIN);
            end else if (bus.byteVLD) begin
                model_write(m_filled, bus.byteIN);
            end else begin
                m_padding = 1;
            end
        end
    end

    logic [10:0] got_log[$];
    logic [10:0] exp_log[$];

    // Per-cycle comparison against the model, away from the active edge; also logs every lane write.
    always @(negedge clk) begin
        chk("byteRDY",       int'(bus.byteRDY),       int'(!rst && !m_padding));
        chk("laneWE",        int'(bus.laneWE),        int'(m_we));
        chk("groupDoneOUT",  int'(bus.groupDoneOUT),  int'(m_done));
        chk("activeModeOUT", int'(bus.activeModeOUT), int'(m_mode));
        chk("padCountOUT",   int'(bus.padCountOUT),   m_pads);
        if (m_we != 0) begin
            chk("laneByteOUT", int'(bus.laneByteOUT), int'(m_byte));
            chk("laneSelOUT",  int'(bus.laneSelOUT),  int'(m_sel));
        end
        if (bus.laneWE != 0)
            got_log.push_back({bus.groupDoneOUT, bus.laneSelOUT, bus.laneByteOUT});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit v, input logic [7:0] d, input logic [1:0] m);
        bus.byteVLD    = v;
        bus.byteIN     = d;
        bus.laneModeIN = m;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 2'b10);
        rst = 1'b0;
        got_log.delete();
        exp_log.delete();
    endtask

    task automatic ew(input bit done, input logic [1:0] lane, input logic [7:0] data);
        exp_log.push_back({done, lane, data});
    endtask

    task automatic check_log(input string name);
        chk({name, "_writes"}, got_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++)
            chk($sformatf("%s_w%0d", name, i), int'(got_log[i]), int'(exp_log[i]));
    endtask

    initial begin
        rst            = 1'b1;
        bus.byteVLD    = 1'b0;
        bus.byteIN     = 8'h00;
        bus.laneModeIN = 2'b10;
        idle(2, 2'b10);
        @(negedge clk);
        chk("rst_laneWE", int'(bus.laneWE), 0);
        chk("rst_mode",   int'(bus.activeModeOUT), 2);
        chk("rst_pad",    int'(bus.padCountOUT), 0);
        chk("rst_rdy",    int'(bus.byteRDY), 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // x4 continuous stream
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 2'b10);
        idle(2, 2'b10);
        for (int i = 0; i < 8; i++) ew(i % 4 == 3, 2'(i % 4), 8'(8'h10 + i));
        check_log("x4_stream");

        // x4 partial group closed by PAD
        do_reset();
        cyc(1'b1, 8'hA0, 2'b10);
        cyc(1'b1, 8'hA1, 2'b10);
        idle(4, 2'b10);
        ew(0, 0, 8'hA0); ew(0, 1, 8'hA1); ew(0, 2, 8'hF7); ew(1, 3, 8'hF7);
        check_log("x4_pad");
        chk("x4_pad_count", int'(bus.padCountOUT), 2);

        // x2 with odd byte count
        do_reset();
        cyc(1'b1, 8'h01, 2'b01);
        cyc(1'b1, 8'h02, 2'b01);
        cyc(1'b1, 8'h03, 2'b01);
        idle(3, 2'b01);
        ew(0, 0, 8'h01); ew(1, 1, 8'h02); ew(0, 0, 8'h03); ew(1, 1, 8'hF7);
        check_log("x2");
        chk("x2_mode",      int'(bus.activeModeOUT), 1);
        chk("x2_pad_count", int'(bus.padCountOUT), 1);

        // x1 with gaps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h50 + i), 2'b00);
            idle(1, 2'b00);
            ew(1, 0, 8'(8'h50 + i));
        end
        idle(1, 2'b00);
        check_log("x1");
        chk("x1_pad_count", int'(bus.padCountOUT), 0);

        // mode change mid-group is deferred to the next idle cycle
        do_reset();
        cyc(1'b1, 8'h30, 2'b10);
        for (int i = 1; i < 6; i++) cyc(1'b1, 8'(8'h30 + i), 2'b01);
        idle(3, 2'b01);
        ew(0, 0, 8'h30); ew(0, 1, 8'h31); ew(0, 2, 8'h32); ew(1, 3, 8'h33);
        ew(0, 0, 8'h34); ew(1, 1, 8'h35);
        check_log("mode_switch");
        chk("mode_switch_mode", int'(bus.activeModeOUT), 1);

        // reset mid-group abandons it
        do_reset();
        cyc(1'b1, 8'h40, 2'b10);
        cyc(1'b1, 8'h41, 2'b10);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 2'b10);
        @(negedge clk);
        chk("midrst_laneWE", int'(bus.laneWE), 0);
        chk("midrst_done",   int'(bus.groupDoneOUT), 0);
        chk("midrst_rdy",    int'(bus.byteRDY), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        cyc(1'b1, 8'h42, 2'b10);
        idle(5, 2'b10);
        ew(0, 0, 8'h40); ew(0, 1, 8'h41);
        ew(0, 0, 8'h42); ew(0, 1, 8'hF7); ew(0, 2, 8'hF7); ew(1, 3, 8'hF7);
        check_log("midrst");
        chk("midrst_pad_count", int'(bus.padCountOUT), 3);

        // reserved mode acts as x4; PAD counter saturates (3-bit here)
        do_reset();
        for (int g = 0; g < 3; g++) begin
            cyc(1'b1, 8'(8'h60 + g), 2'b11);
            idle(5, 2'b11);
        end
        chk("sat_mode",      int'(bus.activeModeOUT), 2);
        chk("sat_pad_count", int'(bus.padCountOUT), 7);
        chk("sat_writes",    got_log.size(), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_striping_ctrl.md
Name: byte_striping_ctrl

Overview:
Sequencing controller in front of the 4-lane byte striper. Accepts a byte stream over a valid/ready handshake and assigns each byte round-robin to the active lanes. Closes every partial stripe group with PAD bytes so that all active lanes advance together. Runtime-configurable for x1/x2/x4 lane widths, and reports stripe-group completion and PAD statistics.

Parameters:
PAD_BYTE, 8'hF7, byte inserted into unfilled lanes when a group closes early
PAD_CNT_W, 16, width of saturating PAD statistics counter

Ports:
stripingCtrlCLK  input  1  single block clock, all logic on posedge
stripingCtrlRST  input  1  reset, synchronous, active-high
byteIN  input  8  upstream data byte
byteVLD  input  1  upstream byte valid
byteRDY  output  1  controller can accept byte this cycle
laneModeIN  input  2  requested width: 00=x1, 01=x2, 10=x4, 11=reserved (treated as x4)
laneByteOUT  output  8  byte presented to striper lane
laneSelOUT  output  2  lane index of laneByteOUT
laneWE  output  4  one-hot lane write strobe; 0 = no write
groupDoneOUT  output  1  one-cycle pulse: last active lane of a group written this cycle
activeModeOUT  output  2  currently latched lane mode (00/01/10)
padCountOUT  output  PAD_CNT_W  total PAD bytes inserted, saturating

Behaviour:
- Synchronous, active-high reset on stripingCtrlRST. All other logic on posedge stripingCtrlCLK.
- Reset values: state=IDLE, laneIdx=0, laneByteOUT=0, laneSelOUT=0, laneWE=0, groupDoneOUT=0, activeModeOUT=2'b10, padCountOUT=0.
- N = active lane count: 1, 2 or 4 per activeModeOUT.
- Handshake:
  - Transfer occurs when byteVLD && byteRDY.
  - byteRDY = !stripingCtrlRST && state!=PAD. It is combinational from registered state.
  - Upstream holds byteIN stable while byteVLD && !byteRDY.
- Latency: an accepted byte appears on laneByteOUT/laneSelOUT/laneWE on the next clock edge, i.e. 1 cycle. All outputs except byteRDY are registered. laneWE is 0 on any cycle without a write.
- State IDLE (laneIdx==0, no group open):
  - Every cycle, activeModeOUT <= laneModeIN (11 maps to 10).
  - On transfer: write the byte to lane 0 and set laneIdx=1.
    - If N==1: pulse groupDoneOUT, set laneIdx=0, stay IDLE.
    - Otherwise: go to STRIPE.
  - The mode used for this byte is the mode latched on the same edge, i.e. the laneModeIN value at the transfer.
- State STRIPE (group open, 0<laneIdx<N):
  - activeModeOUT is frozen.
  - On transfer: write the byte to lane laneIdx, then laneIdx++.
    - If the written lane was N-1: pulse groupDoneOUT, set laneIdx=0, go to IDLE.
  - If byteVLD==0: no write this cycle; go to PAD next cycle.
- State PAD:
  - byteRDY=0.
  - Each cycle: write PAD_BYTE to lane laneIdx, padCountOUT++ (saturates at all-ones), laneIdx++.
  - On writing lane N-1: pulse groupDoneOUT, set laneIdx=0, go to IDLE.
  - PAD is never entered with laneIdx==0. In x1 mode, PAD is never entered.
- laneModeIN changes while in STRIPE or PAD are ignored until the next IDLE cycle.
- Back-to-back groups: a continuous byteVLD stream writes lanes 0..N-1 repeatedly with no bubble. The IDLE pass between groups costs no cycle, because the group-closing write and the next lane-0 write occur on consecutive cycles.
- Reset mid-group abandons the open group: no PAD, no groupDoneOUT. laneWE is 0 from the first edge with reset asserted.
- padCountOUT saturates and never wraps. It is cleared only by reset.

Test Plan:
- Reset, then x4 mode, 8 consecutive bytes 0x10..0x17 with byteVLD held high -> laneWE sequence 1,2,4,8,1,2,4,8 one cycle after each transfer; laneByteOUT 0x10..0x17; groupDoneOUT pulses with bytes 0x13 and 0x17; byteRDY stays 1.
- x4 mode, 2 bytes 0xA0,0xA1, then byteVLD=0 -> lanes 0,1 get 0xA0,0xA1; next 2 cycles lanes 2,3 get 0xF7 with byteRDY=0; groupDoneOUT on lane-3 write; padCountOUT=2.
- x2 mode, 3 bytes 0x01..0x03, then idle -> lanes 0,1,0 written, then lane 1 gets 0xF7; activeModeOUT=01; groupDoneOUT pulses twice; padCountOUT=1.
- x1 mode, 4 bytes with gaps between them -> every write on lane 0 (laneWE=1); groupDoneOUT with each write; padCountOUT stays 0.
- laneModeIN switched from 10 to 01 after the first byte of an x4 group -> group completes as x4 (lanes 0..3); next group uses lanes 0,1; activeModeOUT updates only in IDLE.
- Reset asserted the cycle after lane 1 is written in x4 mode -> no PAD writes, no groupDoneOUT, laneWE=0, byteRDY=0 during reset; after release a new byte is written to lane 0.
